// File: rtl/video_pkg.sv
// video_pkg
// Shared video constants and helpers for the RGB -> YCbCr 4:2:2 path.
//   - BT.601 limited-range coefficients (8 fractional bits), stored as
//     signed ACC_W-bit values so every product and sum stays in one width.
//   - Y/C offsets, clamp limits and blanking levels.
//   - ycbcr_t pixel struct and the 4:2:2 chroma phase enum.
//   - Helpers: coefficient multiply, scale+offset+clamp, rounded average.
package video_pkg;

  localparam int PIX_W     = 8;
  localparam int ACC_W     = 18;
  localparam int FRAC_BITS = 8;

  // Luma coefficients
  localparam logic signed [ACC_W-1:0] K_YR  =  18'sd66;
  localparam logic signed [ACC_W-1:0] K_YG  =  18'sd129;
  localparam logic signed [ACC_W-1:0] K_YB  =  18'sd25;
  // Blue-difference coefficients
  localparam logic signed [ACC_W-1:0] K_CBR = -18'sd38;
  localparam logic signed [ACC_W-1:0] K_CBG = -18'sd74;
  localparam logic signed [ACC_W-1:0] K_CBB =  18'sd112;
  // Red-difference coefficients
  localparam logic signed [ACC_W-1:0] K_CRR =  18'sd112;
  localparam logic signed [ACC_W-1:0] K_CRG = -18'sd94;
  localparam logic signed [ACC_W-1:0] K_CRB = -18'sd18;

  // Half an LSB of the fractional part, added before the floor shift
  localparam logic signed [ACC_W-1:0] ROUND_HALF = 18'sd128;

  localparam logic signed [ACC_W-1:0] Y_OFS = 18'sd16;
  localparam logic signed [ACC_W-1:0] C_OFS = 18'sd128;

  localparam logic signed [ACC_W-1:0] Y_MIN = 18'sd16;
  localparam logic signed [ACC_W-1:0] Y_MAX = 18'sd235;
  localparam logic signed [ACC_W-1:0] C_MIN = 18'sd16;
  localparam logic signed [ACC_W-1:0] C_MAX = 18'sd240;

  localparam logic [PIX_W-1:0] BLANK_Y = 8'h10;
  localparam logic [PIX_W-1:0] BLANK_C = 8'h80;

  typedef struct packed {
    logic [PIX_W-1:0] y;
    logic [PIX_W-1:0] cb;
    logic [PIX_W-1:0] cr;
  } ycbcr_t;

  // Chroma slot of the current pixel within an active run
  typedef enum logic {
    PH_CB = 1'b0,
    PH_CR = 1'b1
  } phase_e;

  // Signed coefficient times an unsigned 8-bit component
  function automatic logic signed [ACC_W-1:0] mul_coef(
    input logic signed [ACC_W-1:0] k,
    input logic [PIX_W-1:0]        p
  );
    logic signed [ACC_W-1:0] px;
    px = $signed({{(ACC_W-PIX_W){1'b0}}, p});
    return k * px;
  endfunction

  // Floor-shift out the fraction, add the offset, clamp to [lo, hi]
  function automatic logic [PIX_W-1:0] scale_clamp(
    input logic signed [ACC_W-1:0] sum,
    input logic signed [ACC_W-1:0] ofs,
    input logic signed [ACC_W-1:0] lo,
    input logic signed [ACC_W-1:0] hi
  );
    logic signed [ACC_W-1:0] v;
    v = (sum >>> FRAC_BITS) + ofs;
    if (v < lo) begin
      v = lo;
    end else if (v > hi) begin
      v = hi;
    end
    return PIX_W'(v);
  endfunction

  // (a + b + 1) >> 1 without overflow
  function automatic logic [PIX_W-1:0] avg_round(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b
  );
    return PIX_W'(({1'b0, a} + {1'b0, b} + (PIX_W+1)'(1)) >> 1);
  endfunction

endpackage

// File: rtl/rgb2ycbcr_core.sv
// rgb2ycbcr_core
// Full-rate RGB -> YCbCr 4:4:4 converter, three register stages:
//   S1 registers the inputs, S2 forms the nine products,
//   S3 sums, rounds, offsets and clamps.
// Ports:
//   pixel_clk, reset_n (async, active-low)
//   in_de, in_r, in_g, in_b : input strobe and unsigned components
//   de_s3                   : in_de delayed by three registers
//   pix_s3                  : converted pixel aligned with de_s3
module rgb2ycbcr_core
  import video_pkg::*;
(
  input  logic             pixel_clk,
  input  logic             reset_n,
  input  logic             in_de,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  output logic             de_s3,
  output ycbcr_t           pix_s3
);

  // S1
  logic             de_s1;
  logic [PIX_W-1:0] r_s1, g_s1, b_s1;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s1 <= 1'b0;
      r_s1  <= '0;
      g_s1  <= '0;
      b_s1  <= '0;
    end else begin
      de_s1 <= in_de;
      r_s1  <= in_r;
      g_s1  <= in_g;
      b_s1  <= in_b;
    end
  end

  // S2
  logic                    de_s2;
  logic signed [ACC_W-1:0] p_yr, p_yg, p_yb;
  logic signed [ACC_W-1:0] p_cbr, p_cbg, p_cbb;
  logic signed [ACC_W-1:0] p_crr, p_crg, p_crb;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s2 <= 1'b0;
      p_yr  <= '0;
      p_yg  <= '0;
      p_yb  <= '0;
      p_cbr <= '0;
      p_cbg <= '0;
      p_cbb <= '0;
      p_crr <= '0;
      p_crg <= '0;
      p_crb <= '0;
    end else begin
      de_s2 <= de_s1;
      p_yr  <= mul_coef(K_YR,  r_s1);
      p_yg  <= mul_coef(K_YG,  g_s1);
      p_yb  <= mul_coef(K_YB,  b_s1);
      p_cbr <= mul_coef(K_CBR, r_s1);
      p_cbg <= mul_coef(K_CBG, g_s1);
      p_cbb <= mul_coef(K_CBB, b_s1);
      p_crr <= mul_coef(K_CRR, r_s1);
      p_crg <= mul_coef(K_CRG, g_s1);
      p_crb <= mul_coef(K_CRB, b_s1);
    end
  end

  // S3: worst-case |sum| is 220*255+128, well inside 18 signed bits
  logic signed [ACC_W-1:0] sum_y, sum_cb, sum_cr;

  always_comb begin
    sum_y  = p_yr  + p_yg  + p_yb  + ROUND_HALF;
    sum_cb = p_cbr + p_cbg + p_cbb + ROUND_HALF;
    sum_cr = p_crr + p_crg + p_crb + ROUND_HALF;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s3     <= 1'b0;
      pix_s3.y  <= BLANK_Y;
      pix_s3.cb <= BLANK_C;
      pix_s3.cr <= BLANK_C;
    end else begin
      de_s3     <= de_s2;
      pix_s3.y  <= scale_clamp(sum_y,  Y_OFS, Y_MIN, Y_MAX);
      pix_s3.cb <= scale_clamp(sum_cb, C_OFS, C_MIN, C_MAX);
      pix_s3.cr <= scale_clamp(sum_cr, C_OFS, C_MIN, C_MAX);
    end
  end

endmodule

// File: rtl/rgb_to_ycbcr422.sv
// rgb_to_ycbcr422
// RGB 4:4:4 -> YCbCr 4:2:2 converter feeding the ADV7513 pins.
// Optional build macro: CHROMA_AVG_EN
//   undefined : plain decimation, latency 4
//   defined   : each Cb/Cr pair is averaged, latency 5
// Ports:
//   pixel_clk, reset_n (async, active-low)
//   in_de, in_hsync, in_vsync : input strobe and active-low syncs
//   in_r, in_g, in_b          : unsigned 8-bit components
//   data_enable, hsync, vsync : inputs delayed by exactly LAT registers
//   data_Y, data_Cb_Cr        : luma and alternating Cb (even) / Cr (odd)
//
// Streaming interface, no valid/ready: one pixel is accepted every clock
// and in_de alone qualifies it; there is no back-pressure in either
// direction, and every output is registered with the same latency.
module rgb_to_ycbcr422
  import video_pkg::*;
(
  input  logic             pixel_clk,
  input  logic             reset_n,
  input  logic             in_de,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  output logic             data_enable,
  output logic             hsync,
  output logic             vsync,
  output logic [PIX_W-1:0] data_Y,
  output logic [PIX_W-1:0] data_Cb_Cr
);

`ifdef CHROMA_AVG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic   de_s3;
  ycbcr_t pix_s3;

  rgb2ycbcr_core u_core (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .in_de     (in_de),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .de_s3     (de_s3),
    .pix_s3    (pix_s3)
  );

  // Signals presented to the output stage
  logic             stage_de;
  logic [PIX_W-1:0] stage_y;
  logic [PIX_W-1:0] c_sel;
  phase_e           phase_q, phase_d;

`ifdef CHROMA_AVG_EN
  // Pair-alignment register: while an even pixel sits here its odd
  // partner is in S3; while an odd pixel sits here its even partner's
  // Cr has been kept in cr_prev.
  logic             de_a;
  ycbcr_t           pix_a;
  logic [PIX_W-1:0] cr_prev;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_a    <= 1'b0;
      pix_a   <= '{y: BLANK_Y, cb: BLANK_C, cr: BLANK_C};
      cr_prev <= BLANK_C;
    end else begin
      de_a  <= de_s3;
      pix_a <= pix_s3;
      if (de_a) begin
        cr_prev <= pix_a.cr;
      end
    end
  end

  always_comb begin
    stage_de = de_a;
    stage_y  = pix_a.y;
    // S3 holds the odd partner only when DE is still high there;
    // otherwise the even pixel is unpaired and averages with itself.
    if (phase_q == PH_CB) begin
      c_sel = avg_round(pix_a.cb, de_s3 ? pix_s3.cb : pix_a.cb);
    end else begin
      c_sel = avg_round(cr_prev, pix_a.cr);
    end
  end
`else
  always_comb begin
    stage_de = de_s3;
    stage_y  = pix_s3.y;
    c_sel    = (phase_q == PH_CB) ? pix_s3.cb : pix_s3.cr;
  end
`endif

  // Phase restarts at Cb on every run and alternates per active pixel
  always_comb begin
    phase_d = PH_CB;
    if (stage_de) begin
      phase_d = (phase_q == PH_CB) ? PH_CR : PH_CB;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_CB;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Output stage with blanking
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_enable <= 1'b0;
      data_Y      <= BLANK_Y;
      data_Cb_Cr  <= BLANK_C;
    end else begin
      data_enable <= stage_de;
      data_Y      <= stage_de ? stage_y : BLANK_Y;
      data_Cb_Cr  <= stage_de ? c_sel   : BLANK_C;
    end
  end

  // Sync delay lines: LAT registers each, idle-high at reset
  logic [LAT-1:0] hs_sr, vs_sr;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_sr <= '1;
      vs_sr <= '1;
    end else begin
      hs_sr <= {hs_sr[LAT-2:0], in_hsync};
      vs_sr <= {vs_sr[LAT-2:0], in_vsync};
    end
  end

  assign hsync = hs_sr[LAT-1];
  assign vsync = vs_sr[LAT-1];

endmodule

// File: tb/tb_rgb_to_ycbcr422.sv
// tb_rgb_to_ycbcr422
// Self-checking bench for rgb_to_ycbcr422. Every input cycle is logged;
// a reference model derives each output cycle from the log using the
// BT.601 formulas and the 4:2:2 pairing rules. Literal expectations pin
// the model and the exact latency. Honours CHROMA_AVG_EN like the DUT.
module tb_rgb_to_ycbcr422;

`ifdef CHROMA_AVG_EN
  localparam int L   = 5;
  localparam bit AVG = 1'b1;
`else
  localparam int L   = 4;
  localparam bit AVG = 1'b0;
`endif
  localparam int HN = 16384;

  // ---------------- clock / reset ----------------
  logic       pixel_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic       in_de     = 1'b0;
  logic       in_hsync  = 1'b1;
  logic       in_vsync  = 1'b1;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic       data_enable, hsync, vsync;
  logic [7:0] data_Y, data_Cb_Cr;

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  rgb_to_ycbcr422 dut (
    .pixel_clk   (pixel_clk),
    .reset_n     (reset_n),
    .in_de       (in_de),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .data_enable (data_enable),
    .hsync       (hsync),
    .vsync       (vsync),
    .data_Y      (data_Y),
    .data_Cb_Cr  (data_Cb_Cr)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit de;
    bit hs;
    bit vs;
    int r;
    int g;
    int b;
  } in_t;

  in_t hist[HN];

  function automatic in_t idle_entry();
    in_t e;
    e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    e.r = 0; e.g = 0; e.b = 0;
    return e;
  endfunction

  function automatic in_t get_in(int k);
    if (k < 0 || k >= HN) return idle_entry();
    return hist[k];
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int y_of(int r, int g, int b);
    return clampi(((66*r + 129*g + 25*b + 128) >>> 8) + 16, 16, 235);
  endfunction

  function automatic int cb_of(int r, int g, int b);
    return clampi(((-38*r - 74*g + 112*b + 128) >>> 8) + 128, 16, 240);
  endfunction

  function automatic int cr_of(int r, int g, int b);
    return clampi(((112*r - 94*g - 18*b + 128) >>> 8) + 128, 16, 240);
  endfunction

  // Output expected at the cycle whose input was logged at index k
  task automatic model_out(input int k, output bit de, output bit hs,
                           output bit vs, output int y, output int c);
    in_t e, p, n;
    int  ph, j, cb_k, cr_k;
    e  = get_in(k);
    de = e.de; hs = e.hs; vs = e.vs;
    y  = 16; c = 128;
    if (e.de) begin
      // position within the run: count active pixels before k
      ph = 0;
      j  = k - 1;
      p  = get_in(j);
      while (p.de) begin
        ph = ph ^ 1;
        j  = j - 1;
        p  = get_in(j);
      end
      y    = y_of(e.r, e.g, e.b);
      cb_k = cb_of(e.r, e.g, e.b);
      cr_k = cr_of(e.r, e.g, e.b);
      if (!AVG) begin
        c = (ph == 0) ? cb_k : cr_k;
      end else if (ph == 0) begin
        n = get_in(k + 1);
        if (!n.de) n = e;
        c = (cb_k + cb_of(n.r, n.g, n.b) + 1) / 2;
      end else begin
        p = get_in(k - 1);
        c = (cr_of(p.r, p.g, p.b) + cr_k + 1) / 2;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [47:0] exp_q[$];   // {cycle, Y, C} literal expectations
  int          run_q[$];   // lengths of output DE-high runs
  int          run_len = 0;
  bit          prev_de = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(negedge pixel_clk) begin
    bit          e_de, e_hs, e_vs;
    int          e_y, e_c;
    logic [47:0] lit;
    model_out(cyc - L, e_de, e_hs, e_vs, e_y, e_c);
    n_checks++;
    if (data_enable === e_de && hsync === e_hs && vsync === e_vs &&
        data_Y === 8'(e_y) && data_Cb_Cr === 8'(e_c)) begin
      n_pass++;
    end else begin
      $display("FAIL cycle_cmp cyc=%0d got de=%0b hs=%0b vs=%0b y=%0d c=%0d expected de=%0b hs=%0b vs=%0b y=%0d c=%0d",
               cyc, data_enable, hsync, vsync, data_Y, data_Cb_Cr, e_de, e_hs, e_vs, e_y, e_c);
    end
    while (exp_q.size() > 0 && int'(exp_q[0][47:16]) <= cyc) begin
      lit = exp_q.pop_front();
      if (int'(lit[47:16]) == cyc) begin
        chk("lit_y", int'(data_Y), int'(lit[15:8]));
        chk("lit_c", int'(data_Cb_Cr), int'(lit[7:0]));
      end else begin
        chk("lit_missed_cycle", cyc, int'(lit[47:16]));
      end
    end
    if (data_enable === 1'b1) begin
      run_len++;
    end else if (prev_de) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
    prev_de = (data_enable === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit de, input bit hs, input bit vs,
                      input int r, input int g, input int b);
    @(posedge pixel_clk);
    #1;
    in_de = de; in_hsync = hs; in_vsync = vs;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    if (cyc < HN) hist[cyc] = '{de, hs, vs, r, g, b};
  endtask

  task automatic step_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 0, 0, 0);
  endtask

  task automatic pix(input int r, input int g, input int b);
    step(1'b1, 1'b1, 1'b1, r, g, b);
  endtask

  // expectation for the pixel just driven, `off` cycles after L
  task automatic expect_lit(input int off, input int y, input int c);
    exp_q.push_back({32'(cyc + L + off), 8'(y), 8'(c)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < HN; i++) hist[i] = idle_entry();

    // model pins (hand-computed BT.601 values)
    chk("model_white_y",  y_of(255, 255, 255), 235);
    chk("model_white_cb", cb_of(255, 255, 255), 128);
    chk("model_white_cr", cr_of(255, 255, 255), 128);
    chk("model_red_y",    y_of(255, 0, 0), 82);
    chk("model_red_cb",   cb_of(255, 0, 0), 90);
    chk("model_blue_y",   y_of(0, 0, 255), 41);
    chk("model_blue_cr",  cr_of(0, 0, 255), 110);
    chk("model_green_cr", cr_of(0, 255, 0), 34);

    step_idle(3);
    reset_n = 1'b1;
    step_idle(4);

    // white, then the blank level right after it
    pix(255, 255, 255);
    expect_lit(0, 235, 128);
    step_idle(1);
    expect_lit(0, 16, 128);
    step_idle(4);

    // red/blue pair; blank one cycle before red pins the latency
    pix(255, 0, 0);
    expect_lit(-1, 16, 128);
    expect_lit(0, 82, AVG ? 165 : 90);
    pix(0, 0, 255);
    expect_lit(0, 41, AVG ? 175 : 110);
    step_idle(4);

    // 3-pixel run then a new line starting with a single red
    pix(255, 0, 0);
    expect_lit(0, 82, AVG ? 72 : 90);
    pix(0, 255, 0);
    expect_lit(0, 144, AVG ? 137 : 34);
    pix(255, 0, 0);
    expect_lit(0, 82, 90);
    step_idle(3);
    pix(255, 0, 0);
    expect_lit(0, 82, 90);
    step_idle(4);

    // random runs with random syncs
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 15) != 0, $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255));
    end
    // DE toggling every cycle: runs of length one
    for (int i = 0; i < 300; i++) begin
      step(i[0], 1'b1, 1'b1, $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255));
    end

    // mid-line reset
    step_idle(L + 2);
    for (int i = 0; i < 10; i++) pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    pix(10, 20, 30);
    reset_n = 1'b0;
    for (int k = cyc - L; k <= cyc; k++) hist[k] = idle_entry();
    #1;
    chk("rst_data_enable", int'(data_enable), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_data_y", int'(data_Y), 16);
    chk("rst_data_c", int'(data_Cb_Cr), 128);
    step_idle(2);
    reset_n = 1'b1;
    step_idle(2);
    pix(255, 0, 0);
    expect_lit(-1, 16, 128);
    expect_lit(0, 82, 90);
    step_idle(L + 6);

    // 1280-wide frame timing, 4 lines of 1650 clocks, vsync on line 0
    run_q.delete();
    for (int ln = 0; ln < 4; ln++) begin
      for (int x = 0; x < 1650; x++) begin
        step((x >= 260) && (x < 1540), x >= 40, ln != 0,
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      end
    end
    step_idle(L + 3);
    chk("frame_line_count", run_q.size(), 4);
    foreach (run_q[i]) chk("frame_de_per_line", run_q[i], 1280);

    step_idle(L + 3);
    chk("lit_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_to_ycbcr422.md
# rgb_to_ycbcr422

Pipelined colour-space converter and chroma subsampler that sits directly upstream of the ADV7513 HDMI transmitter interface. It takes a 24-bit RGB pixel stream with DE/HSYNC/VSYNC from the video pipeline and produces 16-bit YCbCr 4:2:2 as Y plus alternating Cb/Cr. Sync and enable are delayed to stay aligned with the data. Output ports match the transmitter's pin-level naming so the block drops in where the test-pattern source currently drives the pins.

## Interface
- BLANK_Y, 8'h10, Y value driven while data_enable is low
- BLANK_C, 8'h80, Cb/Cr value driven while data_enable is low
- pixel_clk  in  1  pixel clock; all logic on its rising edge
- reset_n  in  1  reset, asynchronous, active-low
- in_de  in  1  input active-video strobe, active-high
- in_hsync  in  1  input hsync, active-low, passed through
- in_vsync  in  1  input vsync, active-low, passed through
- in_r, in_g, in_b  in  8 each  input pixel components, unsigned
- data_enable  out  1  delayed in_de
- hsync  out  1  delayed in_hsync
- vsync  out  1  delayed in_vsync
- data_Y  out  8  luma
- data_Cb_Cr  out  8  Cb on even pixels, Cr on odd pixels of each active run

## Operation
- BT.601 limited range, 8-bit fractional coefficients, signed 18-bit intermediates:
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
  - Cb = ((−38R − 74G + 112B + 128) >>> 8) + 128
  - Cr = ((112R − 94G − 18B + 128) >>> 8) + 128
- `>>>` is an arithmetic (floor) shift.
- Clamp Y to 16..235 and Cb/Cr to 16..240 after the offset is added.
- Pixel phase:
  - Cleared to 0 whenever in_de is low.
  - Toggles on every in_de-high cycle.
  - The first pixel of every active run is even (phase 0), so it carries Cb; the next pixel (phase 1) carries Cr.
- Runs of odd length are legal. The final unpaired even pixel uses its own Cb.
- While delayed DE is low, outputs are forced to BLANK_Y/BLANK_C, regardless of pipeline contents.
- Syncs are delayed only, never regenerated or re-polarised.

## Timing
- Reset values:
  - data_enable = 0, hsync = 1, vsync = 1
  - data_Y = BLANK_Y, data_Cb_Cr = BLANK_C
  - phase = 0; all pipeline DE bits = 0
- Pipeline stages:
  - S1 registers the inputs.
  - S2 computes the products.
  - S3 sums, rounds, offsets and clamps.
  - S4 selects Cb/Cr and drives the output registers.
- Latency L (input edge to output edge):
  - L = 4 without CHROMA_AVG_EN.
  - L = 5 with CHROMA_AVG_EN; one extra pair-alignment register is placed after S3.
- de, hsync and vsync pass through exactly L registers. There is no relative skew between any output.
- There is no back-pressure. One pixel is accepted per clock, sustained indefinitely.
- in_de toggling every cycle (runs of length 1): every such pixel is even and outputs its own Cb.
- Reset asserted mid-line:
  - All outputs take their reset values immediately (asynchronous).
  - After release, outputs stay at blank/idle for L cycles.

## Configuration
- CHROMA_AVG_EN defined:
  - Even pixel outputs Cb = (Cb_even + Cb_odd + 1) >> 1.
  - Odd pixel outputs Cr = (Cr_even + Cr_odd + 1) >> 1.
  - L = 5.
  - An unpaired last pixel averages with itself.
- Not defined:
  - Plain decimation: even pixel outputs its own Cb, odd pixel outputs its own Cr.
  - L = 4.

## Structure
- A shared package `video_pkg` holds:
  - the coefficient localparams (K_YR … K_CRB);
  - the Y/C offsets;
  - the clamp limits;
  - the blank constants.
- One sub-module, `rgb2ycbcr_core`, holds S1–S3 (full-rate 4:4:4 Y/Cb/Cr with clamp and a delayed DE). The top level adds:
  - phase tracking;
  - the optional averaging register;
  - 4:2:2 mux;
  - sync delay;
  - output blanking.

## Test plan
- White: RGB 255,255,255 → Y=235, Cb=Cr=128 (blank check with DE low: Y=16, C=128).
- Red then blue pair, no averaging:
  - Red pixel → Y=82, Cb=90.
  - Blue pixel → Y=41, Cr=110.
  - Red output appears exactly 4 cycles after the input edge.
- Same pair with CHROMA_AVG_EN:
  - Red output Cb = (90+240+1)>>1 = 165.
  - Blue output Cr = (240+110+1)>>1 = 175.
  - Latency is 5.
- 3-pixel run (red, green 0,255,0, red), then DE low:
  - Cb/Cr sequence is Cb, Cr, Cb.
  - The third pixel uses its own Cb = 90.
  - Phase restarts at Cb on the next line.
- Full 1280×720 frame timing through the block:
  - Output DE/HSYNC/VSYNC equal the inputs shifted by L for every cycle of the frame.
  - Exactly 1280 DE-high cycles per active line.
- Reset pulse mid-line:
  - Outputs at reset values within the same cycle.
  - First valid pixel appears L cycles after the first post-reset in_de.
